mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It takes rs/rt operands straight from the register-file read ports (RdData1/RdData2) when the decoder issues MULT/MULTU/DIV/DIVU. It computes over 33 cycles while holding `busy` so the control unit stalls. It also serves MFHI/MFLO through `hi`/`lo` and MTHI/MTLO through `wr_data`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the implementation must also be correct for any even WIDTH ≥ 8.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `opa`  in  WIDTH  rs operand (multiplicand / dividend).
- `opb`  in  WIDTH  rt operand (multiplier / divisor).
- `mthi`  in  1  write `wr_data` to HI.
- `mtlo`  in  1  write `wr_data` to LO.
- `wr_data`  in  WIDTH  MTHI/MTLO data (rs).
- `busy`  out  1  operation in progress; the core stalls while high.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `div_by_zero`  out  1  pulses with `done` when a DIV/DIVU had `opb == 0`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE with `start`:**
  - Latch `op`.
  - Signed ops latch |opa| and |opb| plus sign flags. Unsigned ops latch raw values.
  - Clear the accumulator and remainder, set the iteration counter to 0, go to RUN.
- **RUN:** one iteration per cycle, MSB-first for division and LSB-first shift-add for multiplication. The counter runs 0..WIDTH-1. After the iteration with counter = WIDTH-1, go to FIX.
  - Multiply: 2·WIDTH-bit product {acc, mplier}. If mplier[0] is set, add the multiplicand into acc with a WIDTH+1-bit carry, then shift right 1.
  - Divide: restoring. Shift {rem, quo} left 1. If rem ≥ divisor, subtract the divisor and set quo[0].
- **FIX:**
  - Sign correction:
    - Product: negated when the signs differ.
    - Quotient: negated when the signs differ.
    - Remainder: takes the dividend's sign.
  - Write HI/LO:
    - Multiply: HI = upper half, LO = lower half.
    - Divide: LO = quotient, HI = remainder.
  - Go to IDLE and pulse `done`.
- **Divide by zero:** iterations still run (fixed latency). FIX forces LO = all ones and HI = original opa, and pulses `div_by_zero`.
- **Most-negative / -1:** signed division of the most-negative value by -1 gives LO = 0x80000000 and HI = 0. This falls out of unsigned magnitude arithmetic; no special case is needed.
- **MTHI/MTLO:** take effect at the edge in IDLE only. Both together write both registers. They are ignored while `busy`.
- **Simultaneous events:**
  - `start` together with `mthi`/`mtlo` in IDLE: start wins, and the move is dropped.
  - `start` while busy: ignored.
- `opa`/`opb`/`op` need be valid only in the start cycle.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `div_by_zero` 0, `hi` 0, `lo` 0, counter 0.
- `start` accepted at edge E0. `busy` (registered) is high from after E0 until after E33.
- RUN iterations occur at E1..E32; the FIX write happens at E33.
- **Latency:**
  - `hi`/`lo` show the result, and `done` is high, in the cycle after E33.
  - `busy` is low in that same cycle.
  - A new `start` may be accepted at E34.
- `done` and `div_by_zero` are registered, exactly one cycle wide.
- `hi`/`lo` are stable from E0 through E33 and show the previous values; MFHI during busy is stalled by the core.
- **Reset mid-operation:** immediate abort to the reset values. No `done` is produced and no partial result is written.

## Structure
- Shared package `mdu_pkg`:
  - `op` encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: IDLE, RUN, FIX.
  - Two's-complement `abs`/`neg` functions.
- No sub-module is needed. Multiply and divide share one WIDTH+1-bit adder/subtractor and the {acc, low} shift register in a single module.

## Test plan
- MULT opa=0xFFFFFFFF, opb=0x00000002 → after 33 busy cycles, done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU opa=0xFFFFFFFF, opb=0x00000002 → HI=0x00000001, LO=0xFFFFFFFE.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIVU opa=7, opb=0 → LO=0xFFFFFFFF, HI=7, div_by_zero=1 together with done. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 in IDLE → hi=0x1234 next cycle. MTLO during busy → lo unchanged. `start` re-pulsed during busy → one done only.
- Start MULT, assert rst at busy cycle 10 → busy/hi/lo/done all 0 immediately, no done afterward. Then a fresh MULT 3×5 → LO=15, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and two's-complement helpers.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Helpers work on a wide container; callers zero-extend in and size-cast
  // out, which keeps the low bits exact for any WIDTH up to MAXW/2.
  localparam int MAXW = 128;

  function automatic logic [MAXW-1:0] neg(input logic [MAXW-1:0] v);
    return ~v + {{(MAXW-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MAXW-1:0] abs(input logic [MAXW-1:0] v, input logic s);
    return s ? neg(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: one shared
// WIDTH+1-bit adder/subtractor, one bit per cycle, fixed 33-cycle latency.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opr;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;    // product high half or partial remainder
  logic [WIDTH-1:0] low;    // multiplier/product low half or quotient
  logic [WIDTH-1:0] a_raw;  // original dividend, returned in HI on /0
  logic             is_div, neg_res, neg_rem, dz;

  // Operand conditioning for the start cycle
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    sa    = ~op[0] & opa[WIDTH-1];
    sb    = ~op[0] & opb[WIDTH-1];
    a_mag = WIDTH'(abs(MAXW'(opa), sa));
    b_mag = WIDTH'(abs(MAXW'(opb), sb));
  end

  // Shared adder: multiply adds opr into acc when the multiplier LSB is set;
  // divide subtracts opr from the left-shifted remainder (carry-in 1).
  logic [WIDTH:0] add_a, add_b, sum;
  logic           cin, borrow;

  always_comb begin
    add_a = {1'b0, acc};
    add_b = low[0] ? {1'b0, opr} : '0;
    cin   = 1'b0;
    if (is_div) begin
      add_a = {acc, low[WIDTH-1]};
      add_b = ~{1'b0, opr};
      cin   = 1'b1;
    end
    sum    = add_a + add_b + {{WIDTH{1'b0}}, cin};
    // Remainder is always below the divisor, so the top bit flags rem < divisor
    borrow = sum[WIDTH];
  end

  // Sign-corrected results presented to the FIX write
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prod = {acc, low};
    if (neg_res) prod = (2*WIDTH)'(neg(MAXW'({acc, low})));
    quo = neg_res ? WIDTH'(neg(MAXW'(low))) : low;
    rem = neg_rem ? WIDTH'(neg(MAXW'(acc))) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opr         <= '0;
      acc         <= '0;
      low         <= '0;
      a_raw       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            opr     <= op[1] ? b_mag : a_mag;
            low     <= op[1] ? a_mag : b_mag;
            acc     <= '0;
            a_raw   <= opa;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            dz      <= op[1] && (opb == '0);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= borrow ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
            low <= {low[WIDTH-2:0], ~borrow};
          end else begin
            acc <= sum[WIDTH:1];
            low <= {sum[0], low[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (dz) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
          done        <= 1'b1;
          div_by_zero <= is_div & dz;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random checks of mult_div_unit against an arithmetic
// reference built on 64-bit signed/unsigned integers.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0, opb = '0, wr_data = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          h = 32'(r); l = 32'(q);
        end else begin
          p = ua / ub; h = p[31:0];
          p = ua % ub; l = h; h = p[31:0];
        end
      end
    endcase
  endfunction

  // Issue one op and follow it to completion. With poke set, a second start
  // and an MTLO are driven mid-operation; both must be ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    logic [31:0] eh, el;
    logic        ez;
    int          n;
    bit          bad_busy, bad_hold;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    mthi = poke; wr_data = $urandom;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    opa = $urandom; opb = $urandom; op = 2'($urandom);
    chk({tag, " busy after start"}, {63'd0, busy}, 64'd1);
    chk({tag, " hi held"}, {32'd0, hi}, {32'd0, exp_hi});
    n = 0; bad_busy = 0; bad_hold = 0;
    while (n < 40) begin
      @(negedge clk);
      start = poke && (n == 5);
      mtlo  = poke && (n == 5);
      wr_data = $urandom;
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy !== 1'b1) bad_busy = 1;
      if (hi !== exp_hi || lo !== exp_lo) bad_hold = 1;
    end
    start = 1'b0; mtlo = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy/hi/lo stable"}, {62'd0, bad_busy, bad_hold}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy low"}, {63'd0, busy}, 64'd0);
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    chk({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ez});
    exp_hi = eh; exp_lo = el;
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, {62'd0, done, div_by_zero}, 64'd0);
  endtask

  initial begin
    int dcnt;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done/dz", {62'd0, done, div_by_zero}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op("MULT -1*2",   2'b00, 32'hFFFF_FFFF, 32'h2, 0);
    do_op("MULTU ~0*2",  2'b01, 32'hFFFF_FFFF, 32'h2, 0);
    do_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'h2, 0);
    do_op("DIVU 7/2",    2'b11, 32'h7, 32'h2, 0);
    do_op("DIVU 7/0",    2'b11, 32'h7, 32'h0, 0);
    do_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("DIV -9/0",    2'b10, 32'hFFFF_FFF7, 32'h0, 0);
    do_op("MULT min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);

    // MTHI / MTLO in IDLE
    @(negedge clk); mthi = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1; mthi = 1'b0;
    exp_hi = 32'h1234;
    chk("mthi hi", {32'd0, hi}, 64'h1234);
    chk("mthi lo untouched", {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;
    chk("mthi+mtlo", {hi, lo}, {exp_hi, exp_lo});

    // Start with a move pending, restart and MTLO while busy
    do_op("DIV -100/7 poke", 2'b10, 32'hFFFF_FF9C, 32'h7, 1);
    do_op("MULTU poke",      2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1);

    // Reset mid-operation
    @(negedge clk); start = 1'b1; op = 2'b00; opa = 32'h1111; opb = 32'h2222;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("abort busy/done", {62'd0, busy, done}, 64'd0);
    chk("abort hi/lo", {hi, lo}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("no done after abort", 64'(dcnt), 64'd0);
    do_op("MULT 3*5", 2'b00, 32'd3, 32'd5, 0);

    // Random operations with edge-biased operands
    for (int i = 0; i < 14; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = $urandom_range(1, 20);
        default: ;
      endcase
      do_op("random", ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
